// File: rtl/beamformer_pkg.sv
// Shared widths, latency floor and product-width helper for the beamformer lane blocks.
// Optional feature macro used by users of this package: CMULT_SAT_EN.
package beamformer_pkg;

  localparam int DEF_NUM_CH      = 8;
  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_COEFF_WIDTH = 16;
  localparam int DEF_OUT_WIDTH   = 16;
  localparam int DEF_SHIFT       = 15;
  localparam int DEF_PIPE_STAGES = 3;
  localparam int MIN_PIPE_STAGES = 2;

  function automatic int prod_width(input int data_width, input int coeff_width);
    return data_width + coeff_width + 1;
  endfunction

endpackage

// File: rtl/cmult_array_pipe_if.sv
// Sample/weight/result bus of the complex multiplier array with valid/ready handshakes.
// Overflow signals are only meaningful when CMULT_SAT_EN is defined.
interface cmult_array_pipe_if
  import beamformer_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int COEFF_WIDTH = DEF_COEFF_WIDTH,
  parameter int OUT_WIDTH   = DEF_OUT_WIDTH
);
  logic [NUM_CH*DATA_WIDTH-1:0]  i_sample_packed;
  logic [NUM_CH*DATA_WIDTH-1:0]  q_sample_packed;
  logic [NUM_CH*COEFF_WIDTH-1:0] coeff_i_packed;
  logic [NUM_CH*COEFF_WIDTH-1:0] coeff_q_packed;
  logic [NUM_CH-1:0]             ch_mask;
  logic                          conj_mode;
  logic                          in_valid;
  logic                          in_ready;
  logic [NUM_CH*2*OUT_WIDTH-1:0] mult_out_packed;
  logic                          out_valid;
  logic                          out_ready;
  logic [NUM_CH-1:0]             ovf_flags;
  logic                          ovf_clr;

  modport master (
    output i_sample_packed, q_sample_packed, coeff_i_packed, coeff_q_packed,
           ch_mask, conj_mode, in_valid, out_ready, ovf_clr,
    input  in_ready, mult_out_packed, out_valid, ovf_flags
  );

  modport slave (
    input  i_sample_packed, q_sample_packed, coeff_i_packed, coeff_q_packed,
           ch_mask, conj_mode, in_valid, out_ready, ovf_clr,
    output in_ready, mult_out_packed, out_valid, ovf_flags
  );
endinterface

// File: rtl/cmult_lane_rs.sv
// One channel: complex multiply (optionally by the conjugate weight), round-half-up, scale.
// With CMULT_SAT_EN the result clamps to OUT_WIDTH, otherwise it wraps.
module cmult_lane_rs
  import beamformer_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int COEFF_WIDTH = DEF_COEFF_WIDTH,
  parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
  parameter int SHIFT       = DEF_SHIFT,
  parameter int PIPE_STAGES = DEF_PIPE_STAGES
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic signed [DATA_WIDTH-1:0]  sample_i,
  input  logic signed [DATA_WIDTH-1:0]  sample_q,
  input  logic signed [COEFF_WIDTH-1:0] coeff_i,
  input  logic signed [COEFF_WIDTH-1:0] coeff_q,
  input  logic                          active,
  input  logic                          conj,
  output logic signed [OUT_WIDTH-1:0]   real_part,
  output logic signed [OUT_WIDTH-1:0]   imag_part,
  output logic                          ovf
);
  localparam int PW    = prod_width(DATA_WIDTH, COEFF_WIDTH);
  localparam int DEPTH = PIPE_STAGES - 1;
  localparam logic signed [PW:0] ROUND   = (PW+1)'(1) << (SHIFT - 1);
  localparam logic signed [PW:0] OUT_MAX = {{(PW+2-OUT_WIDTH){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [PW:0] OUT_MIN = ~OUT_MAX;

  typedef struct packed {
    logic [PW-1:0] ii;
    logic [PW-1:0] qq;
    logic [PW-1:0] qi;
    logic [PW-1:0] iq;
    logic          conj;
    logic          active;
  } prod_t;

  prod_t prod;
  prod_t last;
  prod_t stage [DEPTH];
  logic signed [PW-1:0]        ext_i, ext_q, ext_ci, ext_cq;
  logic signed [PW:0]          re_sum, im_sum, re_scaled, im_scaled;
  logic signed [OUT_WIDTH-1:0] re_next, im_next;
  logic                        re_ovf, im_ovf;

  function automatic logic signed [PW:0] widen(input logic [PW-1:0] p);
    return {p[PW-1], p};
  endfunction

  always_comb begin
    ext_i       = PW'(sample_i);
    ext_q       = PW'(sample_q);
    ext_ci      = PW'(coeff_i);
    ext_cq      = PW'(coeff_q);
    prod.ii     = ext_i * ext_ci;
    prod.qq     = ext_q * ext_cq;
    prod.qi     = ext_q * ext_ci;
    prod.iq     = ext_i * ext_cq;
    prod.conj   = conj;
    prod.active = active;
  end

  // The extra bit over the full product width keeps the rounding add from wrapping.
  always_comb begin
    last      = stage[DEPTH-1];
    re_sum    = last.conj ? widen(last.ii) + widen(last.qq) : widen(last.ii) - widen(last.qq);
    im_sum    = last.conj ? widen(last.qi) - widen(last.iq) : widen(last.qi) + widen(last.iq);
    re_scaled = (re_sum + ROUND) >>> SHIFT;
    im_scaled = (im_sum + ROUND) >>> SHIFT;
    re_ovf    = (re_scaled > OUT_MAX) || (re_scaled < OUT_MIN);
    im_ovf    = (im_scaled > OUT_MAX) || (im_scaled < OUT_MIN);
`ifdef CMULT_SAT_EN
    re_next = (re_scaled > OUT_MAX) ? OUT_MAX[OUT_WIDTH-1:0] :
              (re_scaled < OUT_MIN) ? OUT_MIN[OUT_WIDTH-1:0] : re_scaled[OUT_WIDTH-1:0];
    im_next = (im_scaled > OUT_MAX) ? OUT_MAX[OUT_WIDTH-1:0] :
              (im_scaled < OUT_MIN) ? OUT_MIN[OUT_WIDTH-1:0] : im_scaled[OUT_WIDTH-1:0];
`else
    re_next = re_scaled[OUT_WIDTH-1:0];
    im_next = im_scaled[OUT_WIDTH-1:0];
`endif
    if (!last.active) begin
      re_next = '0;
      im_next = '0;
    end
    ovf = last.active && (re_ovf || im_ovf);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
      real_part <= '0;
      imag_part <= '0;
    end else if (en) begin
      stage[0] <= prod;
      for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
      real_part <= re_next;
      imag_part <= im_next;
    end
  end
endmodule

// File: rtl/cmult_array_pipe.sv
// NUM_CH-wide complex weight multiplier with valid/ready backpressure and sticky overflow flags.
// Define CMULT_SAT_EN for saturation and live ovf_flags; otherwise results wrap and flags read 0.
module cmult_array_pipe
  import beamformer_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int COEFF_WIDTH = DEF_COEFF_WIDTH,
  parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
  parameter int SHIFT       = DEF_SHIFT,
  parameter int PIPE_STAGES = DEF_PIPE_STAGES
) (
  input logic               clk,
  input logic               rst_n,
  cmult_array_pipe_if.slave bus
);
  localparam int STAGES = (PIPE_STAGES < MIN_PIPE_STAGES) ? MIN_PIPE_STAGES : PIPE_STAGES;

  logic [STAGES-1:0]             vld;
  logic                          adv;
  logic [NUM_CH-1:0]             lane_ovf;
  logic [NUM_CH*2*OUT_WIDTH-1:0] mult_out;

  // Every stage moves together; bubbles advance too, so nothing is compressed.
  assign adv                 = bus.out_ready || !vld[STAGES-1];
  assign bus.in_ready        = adv;
  assign bus.out_valid       = vld[STAGES-1];
  assign bus.mult_out_packed = mult_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   vld <= '0;
    else if (adv) vld <= {vld[STAGES-2:0], bus.in_valid};
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_lane
    cmult_lane_rs #(
      .DATA_WIDTH (DATA_WIDTH),
      .COEFF_WIDTH(COEFF_WIDTH),
      .OUT_WIDTH  (OUT_WIDTH),
      .SHIFT      (SHIFT),
      .PIPE_STAGES(STAGES)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (adv),
      .sample_i (bus.i_sample_packed[ch*DATA_WIDTH +: DATA_WIDTH]),
      .sample_q (bus.q_sample_packed[ch*DATA_WIDTH +: DATA_WIDTH]),
      .coeff_i  (bus.coeff_i_packed[ch*COEFF_WIDTH +: COEFF_WIDTH]),
      .coeff_q  (bus.coeff_q_packed[ch*COEFF_WIDTH +: COEFF_WIDTH]),
      .active   (bus.ch_mask[ch]),
      .conj     (bus.conj_mode),
      .real_part(mult_out[ch*2*OUT_WIDTH +: OUT_WIDTH]),
      .imag_part(mult_out[ch*2*OUT_WIDTH+OUT_WIDTH +: OUT_WIDTH]),
      .ovf      (lane_ovf[ch])
    );
  end

`ifdef CMULT_SAT_EN
  logic [NUM_CH-1:0] ovf_flags;
  logic [NUM_CH-1:0] ovf_set;

  // A flag is raised as its beat enters the output register; set beats clear.
  assign ovf_set       = (adv && vld[STAGES-2]) ? lane_ovf : '0;
  assign bus.ovf_flags = ovf_flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_flags <= '0;
    else        ovf_flags <= (ovf_flags & ~{NUM_CH{bus.ovf_clr}}) | ovf_set;
  end
`else
  logic unused_ovf;
  assign unused_ovf    = ^{lane_ovf, bus.ovf_clr};
  assign bus.ovf_flags = '0;
`endif
endmodule
